// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-ported data memory between the CPU MEM stage
// and a DMA/debug-loader port. The CPU has priority. The DMA port runs
// auto-incrementing word bursts. A wait counter forces a starved DMA request
// in, and a burst limit offers a requesting CPU one yield cycle every
// MAX_BURST beats.
module dmem_arbiter #(
  parameter int MAX_WAIT  = 8,  // cycles DMA waits behind cpu_req before forced grant (0 = DMA priority)
  parameter int MAX_BURST = 4,  // consecutive DMA beats before a yield is offered (>= 1)
  parameter int LEN_W     = 8   // width of dma_len
) (
  input  logic             clk,
  input  logic             rst_n,
  // CPU MEM stage
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [31:0]      cpu_addr,
  input  logic [31:0]      cpu_wd,
  output logic [31:0]      cpu_rdata,
  output logic             cpu_stall,
  // DMA / debug loader
  input  logic             dma_req,
  input  logic             dma_we,
  input  logic [31:0]      dma_base,
  input  logic [LEN_W-1:0] dma_len,
  input  logic [31:0]      dma_wd,
  output logic [31:0]      dma_rdata,
  output logic             dma_beat,
  output logic             dma_busy,
  output logic             dma_done,
  // data memory
  output logic             mem_we,
  output logic [31:0]      mem_a,
  output logic [31:0]      mem_wd,
  input  logic [31:0]      mem_rd
);

  // Counter widths; both stay at least one bit wide for the degenerate settings.
  localparam int WW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);

  localparam logic [WW-1:0]    WAIT_LIMIT = WW'(MAX_WAIT);
  localparam logic [BW-1:0]    LAST_BEAT  = BW'(MAX_BURST - 1);
  localparam logic [LEN_W-1:0] ONE_LEFT   = LEN_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE,   // CPU owns dmem; DMA request arbitration
    ST_DMA,    // one DMA beat per cycle
    ST_YIELD,  // single CPU-owned cycle inside a long burst
    ST_DONE    // burst finished; dma_done pulse, CPU owns
  } state_t;

  state_t            state_q,    state_d;
  logic [31:0]       addr_q,     addr_d;
  logic [LEN_W-1:0]  remain_q,   remain_d;
  logic [BW-1:0]     beat_cnt_q, beat_cnt_d;
  logic [WW-1:0]     wait_cnt_q, wait_cnt_d;

  // Read data is shared by both ports; each side knows when it is valid.
  assign cpu_rdata = mem_rd;
  assign dma_rdata = mem_rd;

  // State and burst bookkeeping registers; reset aborts any burst silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      remain_q   <= '0;
      beat_cnt_q <= '0;
      wait_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      beat_cnt_q <= beat_cnt_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next-state, counter updates and dmem ownership muxing.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    state_d    = state_q;
    addr_d     = addr_q;
    remain_d   = remain_q;
    beat_cnt_d = beat_cnt_q;
    wait_cnt_d = wait_cnt_q;

    // CPU owns dmem unless a DMA beat is in progress.
    mem_we    = cpu_req & cpu_we;
    mem_a     = cpu_addr;
    mem_wd    = cpu_wd;
    cpu_stall = 1'b0;
    dma_beat  = 1'b0;
    dma_busy  = (state_q != ST_IDLE);
    dma_done  = (state_q == ST_DONE);

    unique case (state_q)
      ST_IDLE: begin
        if (!dma_req) begin
          wait_cnt_d = '0;
        end else if (dma_len == '0) begin
          // Empty burst: report completion without touching dmem.
          state_d    = ST_DONE;
          wait_cnt_d = '0;
        end else if (!cpu_req || wait_cnt_q == WAIT_LIMIT) begin
          state_d    = ST_DMA;
          addr_d     = dma_base;
          remain_d   = dma_len;
          beat_cnt_d = '0;
          wait_cnt_d = '0;
        end else begin
          // Only reachable with cpu_req high and the limit not yet hit.
          wait_cnt_d = wait_cnt_q + WW'(1);
        end
      end

      ST_DMA: begin
        mem_we     = dma_we;
        mem_a      = addr_q;
        mem_wd     = dma_wd;
        dma_beat   = 1'b1;
        cpu_stall  = cpu_req;
        addr_d     = addr_q + 32'd4;
        remain_d   = remain_q - ONE_LEFT;
        beat_cnt_d = beat_cnt_q + BW'(1);
        if (remain_q == ONE_LEFT) begin
          state_d = ST_DONE;
        end else if (beat_cnt_q == LAST_BEAT) begin
          beat_cnt_d = '0;
          if (cpu_req) state_d = ST_YIELD;
        end
      end

      ST_YIELD: begin
        state_d    = ST_DMA;
        beat_cnt_d = '0;
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized and directed bursts against dmem_arbiter with a
// scoreboard. Each burst pushes its predicted per-cycle behaviour and beat
// records into queues; a monitor pops and compares on every observed cycle
// and every dma_beat.
module tb_dmem_arbiter;

  localparam int MAX_WAIT  = 8;
  localparam int MAX_BURST = 4;
  localparam int LEN_W     = 8;

  // Per-cycle signature: {dma_beat, dma_busy, dma_done, cpu_stall, cpu_owns}
  localparam logic [4:0] K_CPU   = 5'b00001;
  localparam logic [4:0] K_YIELD = 5'b01001;
  localparam logic [4:0] K_DONE  = 5'b01101;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] data;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cpu_req, cpu_we;
  logic [31:0]      cpu_addr, cpu_wd, cpu_rdata;
  logic             cpu_stall;
  logic             dma_req, dma_we;
  logic [31:0]      dma_base, dma_wd, dma_rdata;
  logic [LEN_W-1:0] dma_len;
  logic             dma_beat, dma_busy, dma_done;
  logic             mem_we;
  logic [31:0]      mem_a, mem_wd, mem_rd;

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  logic [31:0] wd_seed;
  logic        mon_en;

  logic [4:0] kind_q [$];
  beat_t      beat_q [$];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.MAX_WAIT(MAX_WAIT), .MAX_BURST(MAX_BURST), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_base(dma_base), .dma_len(dma_len),
    .dma_wd(dma_wd), .dma_rdata(dma_rdata), .dma_beat(dma_beat),
    .dma_busy(dma_busy), .dma_done(dma_done),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  // Data memory model: combinational read, write on posedge, 256 words aliased.
  assign mem_rd = mem[mem_a[9:2]];
  always @(posedge clk) if (mem_we) mem[mem_a[9:2]] <= mem_wd;

  // The DMA requester supplies per-beat write data derived from the beat address.
  assign dma_wd = wd_seed ^ mem_a;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the expected cycle sequence of a burst issued with cpu_req
  // held at ci while waiting and at cb once the burst is granted.
  task automatic push_expect(input logic [31:0] base, input int len, input logic we,
                             input logic ci, input logic cb);
    int    n_idle;
    beat_t b;
    n_idle = (len == 0) ? 1 : (ci ? MAX_WAIT + 1 : 1);
    repeat (n_idle) kind_q.push_back(K_CPU);
    for (int i = 0; i < len; i++) begin
      b.addr = base + 32'(4 * i);
      b.we   = we;
      if (we) begin
        b.data = wd_seed ^ b.addr;
        ref_mem[b.addr[9:2]] = b.data;
      end else begin
        b.data = ref_mem[b.addr[9:2]];
      end
      beat_q.push_back(b);
      kind_q.push_back({1'b1, 1'b1, 1'b0, cb, 1'b0});
      if (cb && ((i + 1) % MAX_BURST == 0) && (i + 1 < len)) kind_q.push_back(K_YIELD);
    end
    kind_q.push_back(K_DONE);
  endtask

  // Monitor: compares every scoreboarded cycle and every DMA beat.
  always @(negedge clk) begin
    logic       own;
    logic [4:0] exp_k;
    beat_t      b;
    if (mon_en && rst_n) begin
      own = (mem_a == cpu_addr) && (mem_wd == cpu_wd) && (mem_we == (cpu_req & cpu_we));
      if (kind_q.size() > 0) begin
        exp_k = kind_q.pop_front();
        check("cycle_kind", 32'({dma_beat, dma_busy, dma_done, cpu_stall, own}), 32'(exp_k));
      end
      if (dma_beat) begin
        if (beat_q.size() == 0) begin
          check("unexpected_beat", 32'(dma_beat), 32'd0);
        end else begin
          b = beat_q.pop_front();
          check("beat_addr", mem_a, b.addr);
          check("beat_we", 32'(mem_we), 32'(b.we));
          check(b.we ? "beat_wdata" : "beat_rdata", b.we ? mem_wd : dma_rdata, b.data);
        end
      end
    end
  end

  // Issue one burst and wait (bounded) for its completion pulse.
  task automatic run_burst(input logic [31:0] base, input int len, input logic we,
                           input logic ci, input logic cb);
    int   n_idle;
    logic got;
    @(posedge clk); #1;
    wd_seed  = $urandom;
    cpu_addr = ($urandom & ~32'h3) | 32'h2;  // never equal to an aligned DMA address
    cpu_wd   = $urandom;
    cpu_we   = 1'b0;
    cpu_req  = ci;
    dma_base = base;
    dma_len  = LEN_W'(len);
    dma_we   = we;
    push_expect(base, len, we, ci, cb);
    dma_req  = 1'b1;
    n_idle = (len == 0) ? 1 : (ci ? MAX_WAIT + 1 : 1);
    repeat (n_idle) begin @(posedge clk); #1; end
    cpu_req = cb;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      got = dma_done;
    end
    check("done_seen", 32'(got), 32'd1);
    #1;
    dma_req = 1'b0;
    cpu_req = 1'b0;
    @(posedge clk); #1;
    check("kind_q_drained", 32'(kind_q.size()), 32'd0);
    check("beat_q_drained", 32'(beat_q.size()), 32'd0);
    kind_q.delete();
    beat_q.delete();
  endtask

  initial begin
    int   nb;
    logic [31:0] base;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end
    mon_en   = 1'b0;
    wd_seed  = '0;
    rst_n    = 1'b0;
    cpu_req  = 1'b1;
    cpu_we   = 1'b1;
    cpu_addr = 32'h10;
    cpu_wd   = 32'h5;
    dma_req  = 1'b1;
    dma_we   = 1'b1;
    dma_base = 32'h200;
    dma_len  = 8'd3;

    // Reset state: CPU drives dmem, DMA side quiet even with dma_req high.
    repeat (2) begin
      @(negedge clk);
      check("rst_mem_we", 32'(mem_we), 32'd1);
      check("rst_mem_a", mem_a, 32'h10);
      check("rst_mem_wd", mem_wd, 32'h5);
      check("rst_dma_flags", 32'({dma_beat, dma_done, dma_busy, cpu_stall}), 32'd0);
    end
    ref_mem[4] = 32'h5;  // the CPU write issued during reset lands in memory
    @(posedge clk); #1;
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
    dma_req = 1'b0;
    @(posedge clk); #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Write burst then readback.
    run_burst(32'h40, 3, 1'b1, 1'b0, 1'b0);
    run_burst(32'h40, 3, 1'b0, 1'b0, 1'b0);
    // Starvation bound, yield pattern, address wrap, empty burst.
    run_burst(32'h80, 2, 1'b1, 1'b1, 1'b1);
    run_burst(32'hC0, 10, 1'b1, 1'b0, 1'b1);
    run_burst(32'hFFFF_FFFC, 2, 1'b1, 1'b0, 1'b0);
    run_burst(32'h300, 0, 1'b0, 1'b1, 1'b1);
    run_burst(32'hC0, 10, 1'b0, 1'b1, 1'b0);

    // Reset in the middle of a burst.
    mon_en = 1'b0;
    @(posedge clk); #1;
    cpu_addr = 32'h1002;
    cpu_wd   = 32'hA5A5_0001;
    cpu_req  = 1'b0;
    dma_base = 32'h100;
    dma_len  = 8'd5;
    dma_we   = 1'b0;
    dma_req  = 1'b1;
    nb = 0;
    for (int i = 0; i < 20 && nb < 2; i++) begin
      @(negedge clk);
      if (dma_beat) begin
        check("rst_mid_beat_addr", mem_a, 32'h100 + 32'(4 * nb));
        nb++;
      end
    end
    check("rst_mid_two_beats", 32'(nb), 32'd2);
    @(posedge clk); #1;
    rst_n   = 1'b0;
    dma_req = 1'b0;
    #1;
    check("rst_mid_busy", 32'({dma_busy, dma_beat, cpu_stall}), 32'd0);
    check("rst_mid_cpu_owns", mem_a, 32'h1002);
    repeat (3) begin
      @(negedge clk);
      check("rst_mid_no_done", 32'(dma_done), 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_cpu_owns", mem_a, 32'h1002);
    check("post_rst_no_done", 32'(dma_done | dma_busy), 32'd0);
    mon_en = 1'b1;
    run_burst(32'h100, 5, 1'b0, 1'b0, 1'b0);

    // Randomized bursts.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) base = 32'hFFFF_FFC0 + 32'($urandom_range(0, 15) << 2);
      else                           base = $urandom & ~32'h3;
      run_burst(base, int'($urandom_range(0, 12)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
